// File: rtl/rv32im_muldiv.sv
// rv32im_muldiv: iterative RV32M multiply/divide unit for the EX stage.
//
// Runs one radix-2 step per cycle: shift-add for multiplies, restoring
// shift-subtract for divides. Operands are converted to magnitudes on issue.
// The sign is applied once at the end. Divide-by-zero and signed overflow
// bypass the iteration and go straight to the finish state.
//
// Configuration macro: RV32IM_FAST_MUL_EN
//   Defined   - multiplies form the full product in one step and skip RUN.
//   Undefined - multiplies use the WIDTH-cycle iterative path.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      issue an M-op (taken only when idle and not busy)
//   i_flush      abort any op in flight; wins over i_start
//   i_muldiv_op  funct3 of the M-op
//   i_rs1_data   dividend / multiplicand
//   i_rs2_data   divisor / multiplier
//   o_busy       op in flight (stall request), includes the o_valid cycle
//   o_valid      one-cycle result strobe
//   o_result     result, held until the next o_valid
module rv32im_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [2:0]       i_muldiv_op,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e               state_q, state_d;
    logic [2:0]           op_q;
    logic                 neg_q;      // final result must be negated
    logic                 direct_q;   // acc_q low half already holds the answer
    logic [2*WIDTH-1:0]   acc_q;      // mul: {product hi, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]     b_q;        // multiplicand or divisor magnitude
    logic [CntW-1:0]      cnt_q;
    logic                 valid_q;
    logic [WIDTH-1:0]     result_q;

    // Issue decode
    logic             start_ok;
    logic             op_is_div;
    logic             rs1_sgn, rs2_sgn;
    logic             rs1_neg, rs2_neg;
    logic [WIDTH-1:0] rs1_abs, rs2_abs;
    logic             div_zero, div_ovf, special, skip_run, res_neg;
    logic [WIDTH-1:0] special_val;

    always_comb begin
        start_ok  = (state_q == StIdle) && !valid_q && i_start && !i_flush;
        op_is_div = i_muldiv_op[2];
        // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed
        rs1_sgn   = (i_muldiv_op == 3'b001) || (i_muldiv_op == 3'b010) ||
                    (i_muldiv_op == 3'b100) || (i_muldiv_op == 3'b110);
        rs2_sgn   = (i_muldiv_op == 3'b001) || (i_muldiv_op == 3'b100) ||
                    (i_muldiv_op == 3'b110);
        rs1_neg   = rs1_sgn && i_rs1_data[WIDTH-1];
        rs2_neg   = rs2_sgn && i_rs2_data[WIDTH-1];
        rs1_abs   = rs1_neg ? -i_rs1_data : i_rs1_data;
        rs2_abs   = rs2_neg ? -i_rs2_data : i_rs2_data;

        div_zero  = op_is_div && (i_rs2_data == '0);
        div_ovf   = op_is_div && !i_muldiv_op[0] &&
                    (i_rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) && (i_rs2_data == '1);
        special   = div_zero || div_ovf;

        // Remainder ops (bit 1 set) return rs1 on /0 and 0 on overflow
        if (div_zero) begin
            special_val = i_muldiv_op[1] ? i_rs1_data : '1;
        end else begin
            special_val = i_muldiv_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
        end

`ifdef RV32IM_FAST_MUL_EN
        skip_run = special || !op_is_div;
`else
        skip_run = special;
`endif

        unique case (i_muldiv_op)
            3'b001, 3'b100: res_neg = rs1_neg ^ rs2_neg;
            3'b010, 3'b110: res_neg = rs1_neg;
            default:        res_neg = 1'b0;
        endcase
    end

    // One iteration step
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift, div_diff;
    logic [2*WIDTH-1:0]   div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        // Borrow out means the trial subtract failed: keep the shifted remainder
        if (div_diff[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Finish: sign correction and half selection
    logic [2*WIDTH-1:0] mul_full;
    logic [WIDTH-1:0]   div_sel, div_fin, fin_result;

    always_comb begin
        mul_full = neg_q ? -acc_q : acc_q;
        div_sel  = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
        div_fin  = neg_q ? -div_sel : div_sel;
        if (direct_q) begin
            fin_result = acc_q[WIDTH-1:0];
        end else if (op_q[2]) begin
            fin_result = div_fin;
        end else if (op_q[1:0] == 2'b00) begin
            fin_result = mul_full[WIDTH-1:0];
        end else begin
            fin_result = mul_full[2*WIDTH-1:WIDTH];
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start_ok) state_d = skip_run ? StFin : StRun;
                StRun:   if (cnt_q == '0) state_d = StFin;
                StFin:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs; the o_valid cycle still counts as busy so the next issue
    // lands in the cycle after it
    always_comb begin
        o_busy   = (state_q != StIdle) || valid_q;
        o_valid  = valid_q;
        o_result = result_q;
    end

    // Datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            direct_q <= 1'b0;
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        op_q     <= i_muldiv_op;
                        neg_q    <= res_neg;
                        direct_q <= special;
                        cnt_q    <= CntW'(WIDTH - 1);
                        if (special) begin
                            acc_q <= {{WIDTH{1'b0}}, special_val};
                        end else if (op_is_div) begin
                            acc_q <= {{WIDTH{1'b0}}, rs1_abs};
                            b_q   <= rs2_abs;
                        end else begin
                            b_q   <= rs1_abs;
`ifdef RV32IM_FAST_MUL_EN
                            acc_q <= {{WIDTH{1'b0}}, rs1_abs} * {{WIDTH{1'b0}}, rs2_abs};
`else
                            acc_q <= {{WIDTH{1'b0}}, rs2_abs};
`endif
                        end
                    end
                end
                StRun: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q - 1'b1;
                end
                StFin: begin
                    if (!i_flush) begin
                        valid_q  <= 1'b1;
                        result_q <= fin_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32im_muldiv.sv
module tb_rv32im_muldiv;

`ifdef RV32IM_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        busy, valid;
    logic [31:0] result;

    always #5 clk = ~clk;

    rv32im_muldiv #(.WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_flush     (flush),
        .i_muldiv_op (op),
        .i_rs1_data  (rs1),
        .i_rs2_data  (rs2),
        .o_busy      (busy),
        .o_valid     (valid),
        .o_result    (result)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %h expected %h (cycle-time %0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        longint      la, lb, q;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        la = longint'($signed(a));
        lb = longint'($signed(b));
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                q = la / lb;
                return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                q = la % lb;
                return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!f[2]) return MUL_LAT;
        if (b == 0) return 2;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
        return 34;
    endfunction

    // Cycle-level model: when the pending result appears and what it is
    longint      cyc = 0;
    longint      valid_at = -1;
    logic [31:0] m_result = 32'h0;
    logic [31:0] pend = 32'h0;
    bit          ready = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            valid_at = -1;
            m_result = 32'h0;
            ready    = 1'b1;
        end else if (flush) begin
            if (valid_at >= cyc) valid_at = -1;
        end else if (start && valid_at < cyc - 1) begin
            valid_at = cyc - 1 + ref_lat(op, rs1, rs2);
            pend     = ref_result(op, rs1, rs2);
        end
        if (!rst && valid_at == cyc) m_result = pend;
    end

    always @(negedge clk) begin
        if (ready) begin
            check("busy", {31'b0, busy}, {31'b0, (valid_at >= cyc)});
            check("valid", {31'b0, valid}, {31'b0, (valid_at == cyc)});
            check("result", result, m_result);
        end
    end

    task automatic wait_valid(input longint t, input logic [31:0] exp, input int lat,
                              input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (valid) begin
                seen = 1'b1;
                check({name, " result"}, result, exp);
                check({name, " latency"}, 32'(cyc - t), 32'(lat));
            end
        end
        if (!seen) check({name, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
        longint t;
        @(posedge clk); #1;
        flush = 1'b0; rst = 1'b0;
        op = f; rs1 = a; rs2 = b; start = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(t, exp, lat, name);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 7)
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom % 16);
            4: return -32'($urandom % 16);
            5: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        longint t;
        int     nvalid;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; rs1 = 32'h0; rs2 = 32'h0;

        // Pin the model with hand-computed values
        check("ref mulh", ref_result(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'h00000000);
        check("ref div", ref_result(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
        check("ref rem ovf", ref_result(3'd6, 32'h80000000, 32'hFFFFFFFF), 32'h0);
        check("ref div ovf", ref_result(3'd4, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset valid", {31'b0, valid}, 32'd0);
        check("reset result", result, 32'd0);

        do_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, "mul");
        do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, "mulhu");
        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT, "mulh");
        do_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MUL_LAT, "mulhsu");
        do_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div");
        do_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "rem");
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 34, "divu");
        do_op(3'd7, 32'd100, 32'd7, 32'd2, 34, "remu");
        do_op(3'd4, 32'h12345678, 32'd0, 32'hFFFFFFFF, 2, "div by zero");
        do_op(3'd7, 32'h12345678, 32'd0, 32'h12345678, 2, "remu by zero");
        do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 2, "rem ovf");
        do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, "div ovf");

        // Flush at t+10, new start at t+11
        @(posedge clk); #1;
        op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1; t = cyc;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1; t = cyc;
        @(negedge clk);
        check("flush busy dropped", {31'b0, busy}, 32'd0);
        check("flush result kept", result, 32'h80000000);
        @(posedge clk); #1 start = 1'b0;
        wait_valid(t, 32'd14, 34, "start after flush");

        // Start while busy is ignored
        @(posedge clk); #1;
        op = 3'd5; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1; t = cyc;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 op = 3'd0; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) begin
                nvalid++;
                check("ignored start result", result, 32'd142);
                check("ignored start latency", 32'(cyc - t), 32'd34);
            end
        end
        check("ignored start valid count", 32'(nvalid), 32'd1);

        // Reset mid-operation
        @(posedge clk); #1;
        op = 3'd4; rs1 = -32'd1000; rs2 = 32'd3; start = 1'b1; t = cyc;
        @(posedge clk); #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid reset busy", {31'b0, busy}, 32'd0);
        check("mid reset valid", {31'b0, valid}, 32'd0);
        check("mid reset result", result, 32'd0);
        repeat (40) @(posedge clk);

        // Random traffic: overlapping starts, occasional flush and reset
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            start = ($urandom % 3) == 0;
            flush = ($urandom % 50) == 0;
            rst   = ($urandom % 700) == 0;
            op    = 3'($urandom % 8);
            rs1   = pick();
            rs2   = pick();
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
